seq_addsub_n: RTL
=================

Name: seq_addsub_n

Overview:
- Parametrised, multi-cycle add/subtract unit; next generation of the team's fixed 8-bit ripple adder.
- Computes a WIDTH-bit sum or difference as CHUNK-bit ripple slices, LSB slice first, one slice per clock. This keeps the carry chain short for timing.
- Valid/ready handshake on both input and output. Produces carry, signed-overflow and zero flags.
- Sits in the ALU datapath between the operand latch and the writeback stage.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per cycle; NUM_CHUNKS = WIDTH/CHUNK (1 allowed).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  unit can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add only)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: state = IDLE; chunk counter = 0. Outputs sum, cout, ovf, zero and out_valid are 0. in_ready = 1 after reset.
- Arithmetic:
  - sub = 0: sum = a + b + cin.
  - sub = 1: sum = a + ~b + 1; cin is ignored.
  - Operands are captured at accept, with b already conditionally inverted.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - zero = (final sum == 0).
- Accept: on an edge where in_valid & in_ready are both high, capture a, b', carry0 and sub. Go to CALC with the counter at 0.
- CALC: each cycle adds slice k (bits k*CHUNK .. k*CHUNK+CHUNK-1) with the registered running carry. The slice result goes into an internal partial register. On the last slice (k = NUM_CHUNKS-1), go to DONE.
- Output registers: sum, cout, ovf and zero update only on the CALC->DONE edge and hold otherwise.
- Latency: out_valid rises exactly NUM_CHUNKS cycles after the accept edge.
- DONE: out_valid = 1 and the outputs are held stable until out_valid & out_ready.
  - If handshake completes and no new accept: go to IDLE; out_valid = 0.
- in_ready = (state == IDLE) | (state == DONE & out_ready). This is combinational from out_ready.
- Simultaneous output handshake and input accept in DONE: result retired, new operands captured, next state CALC. out_valid drops for the CALC cycles.
- in_valid in CALC is ignored; operands are not captured.
- Reset asserted mid-CALC or in DONE: the in-flight operation is discarded and all outputs go to reset values immediately (asynchronous).
- NUM_CHUNKS = 1: a single CALC cycle; latency 1.

Optional Feature:
- Macro: ADDN_SAT_EN.
- Defined: when ovf = 1, sum saturates to the signed limit. If operand A's MSB = 0 (positive overflow), sum = 0x7F..F; otherwise sum = 0x80..0. zero is computed on the saturated value; ovf and cout still report the raw arithmetic result.
- Undefined: sum is the wrapped two's-complement result. No saturation logic is synthesised.

Decomposition:
- Shared package/include alu_defs holds:
  - state encodings: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  - default WIDTH/CHUNK constants;
  - the clog2-style counter-width function.
- One natural sub-module, add_chunk: a combinational CHUNK-bit ripple adder with ports a, b, cin, sum, cout and c_msb_in (carry into its top bit, used for ovf on the final slice). It is instantiated once and time-multiplexed by the counter.

Test Plan (WIDTH = 16, CHUNK = 4 unless stated):
- Add: a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0, zero=0. out_valid exactly 4 cycles after accept.
- Carry/zero: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0.
  - a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- Overflow: a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1, cout=0 (ADDN_SAT_EN: sum=0x7FFF).
  - a=0x8000, b=0x0001 sub -> sum=0x7FFF, ovf=1, cout=1 (ADDN_SAT_EN: sum=0x8000).
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
- Back-pressure: hold out_ready=0 for 3 cycles in DONE -> sum/flags stable, in_ready=0.
  - Then assert out_ready=1 with in_valid=1 (a=0x0001, b=0x0001) in the same cycle -> old result retired, new op accepted, sum=0x0002 after 4 cycles.
- Reset: drop rst_n during the 2nd CALC cycle -> outputs 0 and out_valid=0 immediately; in_ready=1 after release.
  - Repeat with CHUNK=16 -> latency 1.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: FSM encodings, default datapath sizing and counter sizing helper.
// Imported by the sequential add/subtract unit and its slice adder.
package alu_defs;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Bits needed to count 0..n-1, never less than one so a single-slice build still has a counter.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple adder slice; zero latency, no flow control.
// Exposes the carry into its top bit so the caller can form signed overflow.
module add_chunk
    import alu_defs::*;
#(
    parameter int W = DEF_CHUNK
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[W];
    assign c_msb_in = c[W - 1];

endmodule

// File: rtl/seq_addsub_n.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock; result valid NUM_CHUNKS cycles after accept,
// held in DONE until out_ready (in_ready follows out_ready there). ADDN_SAT_EN enables signed saturation.
module seq_addsub_n
    import alu_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CW = cnt_width(NUM_CHUNKS);
    localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] partial;
    logic             carry;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             raw_ovf;
    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] partial_next;
    logic [WIDTH-1:0] result;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign finish    = (state == CALC) & (cnt == LAST);

    // Operands shift right each cycle so the slice adder always sees the low CHUNK bits.
    add_chunk #(.W(CHUNK)) u_chunk (
        .a        (op_a[CHUNK-1:0]),
        .b        (op_b[CHUNK-1:0]),
        .cin      (carry),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    assign partial_next = (partial >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
    assign raw_ovf      = slice_cmsb ^ slice_cout;

`ifdef ADDN_SAT_EN
    logic a_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
        end
    end

    assign result = raw_ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : partial_next;
`else
    assign result = partial_next;
`endif

    // Subtraction is folded in at accept: b is inverted and the +1 rides in on the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            partial <= '0;
            cnt     <= '0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= sub ? ~b : b;
            carry   <= sub | cin;
            partial <= '0;
            cnt     <= '0;
        end else if (state == CALC) begin
            op_a    <= op_a >> CHUNK;
            op_b    <= op_b >> CHUNK;
            carry   <= slice_cout;
            partial <= partial_next;
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (finish) begin
            sum  <= result;
            cout <= slice_cout;
            ovf  <= raw_ovf;
            zero <= (result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state <= CALC;
                CALC: if (cnt == LAST) state <= DONE;
                DONE: if (out_ready) state <= accept ? CALC : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
